// File: rtl/background_scroll_addr_pkg.sv
// Shared geometry constants and helpers for the scaled, scrolling background address path.
package background_scroll_addr_pkg;

  localparam int unsigned SRC_W   = 300;
  localparam int unsigned SRC_H   = 300;
  localparam int unsigned DST_W   = 640;
  localparam int unsigned DST_H   = 480;
  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned SPEED_W = 4;
  localparam int unsigned COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  // Reduce a value known to be < 2*SRC_W into 0..SRC_W-1 with one compare/subtract.
  function automatic coord_t wrap_src_w(input coord_t v);
    if (v >= COORD_W'(SRC_W)) begin
      return COORD_W'(v - COORD_W'(SRC_W));
    end
    return v;
  endfunction

endpackage

// File: rtl/background_scroll_addr_if.sv
// Scan-position inputs, scroll controls and ROM address outputs of the background address stage.
interface background_scroll_addr_if;
  import background_scroll_addr_pkg::*;

  coord_t               DrawX;
  coord_t               DrawY;
  logic                 blank;
  logic                 scroll_en;
  logic [SPEED_W-1:0]   scroll_speed;
  logic [ADDR_W-1:0]    rom_address;
  logic                 blank_out;
  coord_t               scroll_off;

  // VGA timing / control side.
  modport master (
    output DrawX, DrawY, blank, scroll_en, scroll_speed,
    input  rom_address, blank_out, scroll_off
  );

  // Address generator side.
  modport slave (
    input  DrawX, DrawY, blank, scroll_en, scroll_speed,
    output rom_address, blank_out, scroll_off
  );

endinterface

// File: rtl/background_scroll_addr_dda_axis.sv
// One axis of the DST->SRC downscale: idx tracks floor(steps*SRC/DST), clamped at SRC-1.
// Outputs are the next-state values so the caller can register an address in the same cycle.
module background_scroll_addr_dda_axis #(
  parameter int unsigned SRC   = 300,
  parameter int unsigned DST   = 640,
  parameter int unsigned IDX_W = 10,
  parameter int unsigned ERR_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_restart,
  input  logic             i_step,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_carry_c
);

  localparam int unsigned        SUM_W     = ERR_W + 1;
  localparam logic [IDX_W-1:0]   L_IDX_MAX = IDX_W'(SRC - 1);
  localparam logic [SUM_W-1:0]   L_SRC     = SUM_W'(SRC);
  localparam logic [SUM_W-1:0]   L_DST     = SUM_W'(DST);

  logic [IDX_W-1:0] r_idx;
  logic [ERR_W-1:0] r_err;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [ERR_W-1:0] w_err_nxt;
  logic [SUM_W-1:0] w_err_sum;
  logic             w_carry;

  // Error accumulator step: add SRC, and on overflow past DST advance idx by one.
  always_comb begin
    w_idx_nxt = r_idx;
    w_err_nxt = r_err;
    w_carry   = 1'b0;
    w_err_sum = {1'b0, r_err} + L_SRC;
    if (i_restart) begin
      w_idx_nxt = '0;
      w_err_nxt = '0;
    end else if (i_step && (r_idx < L_IDX_MAX)) begin
      if (w_err_sum >= L_DST) begin
        w_err_nxt = ERR_W'(w_err_sum - L_DST);
        w_idx_nxt = r_idx + IDX_W'(1);
        w_carry   = 1'b1;
      end else begin
        w_err_nxt = ERR_W'(w_err_sum);
      end
    end
  end

  // Accumulator state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_err <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign o_idx_c   = w_idx_nxt;
  assign o_carry_c = w_carry;

endmodule

// File: rtl/background_scroll_addr.sv
// Maps the 640x480 scan position onto the SRC_W x SRC_H background ROM with a per-frame,
// wrapping horizontal scroll. One cycle of latency; no multipliers or dividers.
module background_scroll_addr (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  background_scroll_addr_if.slave bus
);
  import background_scroll_addr_pkg::*;

  localparam coord_t            L_DST_W    = COORD_W'(DST_W);
  localparam coord_t            L_DST_H    = COORD_W'(DST_H);
  localparam logic [ADDR_W-1:0] L_ROW_STEP = ADDR_W'(SRC_W);

  logic              w_x_zero;
  logic              w_x_active;
  logic              w_y_zero;
  logic              w_scroll_upd;
  coord_t            w_col_c;
  coord_t            w_row_idx_unused;
  logic              w_col_carry_unused;
  logic              w_row_carry;
  coord_t            w_col_sum;
  coord_t            w_col_wrap;
  coord_t            w_scroll_sum;
  coord_t            w_scroll_nxt;
  logic [ADDR_W-1:0] w_row_base_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;

  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_rom_address;
  logic              r_blank_out;
  coord_t            r_scroll_off;

  // Scan position decode.
  always_comb begin
    w_x_zero     = (bus.DrawX == '0);
    w_x_active   = (bus.DrawX < L_DST_W);
    w_y_zero     = (bus.DrawY == '0);
    w_scroll_upd = w_x_zero && (bus.DrawY == L_DST_H) && bus.scroll_en;
  end

  background_scroll_addr_dda_axis #(
    .SRC   (SRC_W),
    .DST   (DST_W),
    .IDX_W (COORD_W),
    .ERR_W (COORD_W)
  ) u_col_dda (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .i_restart (w_x_zero),
    .i_step    (w_x_active),
    .o_idx_c   (w_col_c),
    .o_carry_c (w_col_carry_unused)
  );

  // Row steps once per line at DrawX==0; the column restart happens in the same cycle.
  background_scroll_addr_dda_axis #(
    .SRC   (SRC_H),
    .DST   (DST_H),
    .IDX_W (COORD_W),
    .ERR_W (COORD_W)
  ) u_row_dda (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .i_restart (w_x_zero && w_y_zero),
    .i_step    (w_x_zero),
    .o_idx_c   (w_row_idx_unused),
    .o_carry_c (w_row_carry)
  );

  // Row base follows the row index in SRC_W increments; scrolled column wraps inside the row.
  always_comb begin
    w_row_base_nxt = r_row_base;
    if (w_x_zero && w_y_zero) begin
      w_row_base_nxt = '0;
    end else if (w_row_carry) begin
      w_row_base_nxt = r_row_base + L_ROW_STEP;
    end
    w_col_sum  = w_col_c + r_scroll_off;
    w_col_wrap = wrap_src_w(w_col_sum);
    w_addr_nxt = w_row_base_nxt + ADDR_W'(w_col_wrap);
  end

  // Scroll advances only at the frame-update point, which sits in vertical blank.
  always_comb begin
    w_scroll_sum = r_scroll_off + COORD_W'(bus.scroll_speed);
    w_scroll_nxt = r_scroll_off;
    if (w_scroll_upd) begin
      w_scroll_nxt = wrap_src_w(w_scroll_sum);
    end
  end

  // Output and scroll registers.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_row_base    <= '0;
      r_rom_address <= '0;
      r_blank_out   <= 1'b0;
      r_scroll_off  <= '0;
    end else begin
      r_row_base    <= w_row_base_nxt;
      r_rom_address <= w_addr_nxt;
      r_blank_out   <= bus.blank;
      r_scroll_off  <= w_scroll_nxt;
    end
  end

  assign bus.rom_address = r_rom_address;
  assign bus.blank_out   = r_blank_out;
  assign bus.scroll_off  = r_scroll_off;

endmodule

// File: tb/tb_background_scroll_addr.sv
// Scoreboard bench: the driver pushes the expected response for each driven scan position,
// the monitor pops and compares one cycle later.
module tb_background_scroll_addr;
  import background_scroll_addr_pkg::*;

  localparam int MODE_EXACT = 1;
  localparam int MODE_BOUND = 2;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  background_scroll_addr_if bus();

  background_scroll_addr dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int    stamp;
    int    mode;
    int    addr;
    int    blank;
    int    scroll;
    string tag;
  } exp_t;

  typedef struct {
    int x;
    int y;
    int s;
    int addr;
  } vec_t;

  // Hand-computed directed points: (x, y, scroll_off) -> rom_address.
  vec_t vecs [6] = '{
    '{x:0,   y:0,   s:0,  addr:0},
    '{x:639, y:0,   s:0,  addr:299},
    '{x:0,   y:479, s:0,  addr:89700},
    '{x:639, y:479, s:0,  addr:89999},
    '{x:0,   y:0,   s:10, addr:10},
    '{x:639, y:0,   s:10, addr:9}
  };

  exp_t  exp_q [$];
  exp_t  mon_e;
  int    cyc      = 0;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    m_scroll = 0;
  string phase    = "init";

  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input string what, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d, expected %0d (cycle %0d)", tag, what, act, req, cyc);
    end
  endtask

  // Monitor: compare DUT outputs against every expectation whose input edge has passed.
  always @(negedge vga_clk) begin
    while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
      mon_e = exp_q.pop_front();
      check(mon_e.tag, "blank_out", int'(bus.blank_out), mon_e.blank);
      check(mon_e.tag, "scroll_off", int'(bus.scroll_off), mon_e.scroll);
      if (mon_e.mode == MODE_EXACT) begin
        check(mon_e.tag, "rom_address", int'(bus.rom_address), mon_e.addr);
      end else begin
        check(mon_e.tag, "addr_in_range", int'(bus.rom_address < 17'd90000), 1);
      end
    end
  end

  // Drive one scan position for one cycle and queue the expected registered response.
  task automatic drive(input int x, input int y, input bit rst, input int mode);
    exp_t e;
    int   col;
    int   row;
    int   a;
    bus.DrawX = COORD_W'(x);
    bus.DrawY = COORD_W'(y);
    bus.blank = (x < 640) && (y < 480);
    reset_n   = !rst;
    e.stamp = cyc;
    e.tag   = phase;
    e.mode  = mode;
    if (rst) begin
      m_scroll = 0;
      e.mode   = MODE_EXACT;
      e.addr   = 0;
      e.blank  = 0;
      e.scroll = 0;
    end else begin
      col = (x < 640) ? (x * 300) / 640 : 299;
      row = (y * 300) / 480;
      if (row > 299) row = 299;
      a = row * 300 + (col + m_scroll) % 300;
      foreach (vecs[i]) begin
        if (vecs[i].x == x && vecs[i].y == y && vecs[i].s == m_scroll) a = vecs[i].addr;
      end
      e.addr  = a;
      e.blank = ((x < 640) && (y < 480)) ? 1 : 0;
      if (x == 0 && y == 480 && bus.scroll_en) m_scroll = (m_scroll + int'(bus.scroll_speed)) % 300;
      e.scroll = m_scroll;
    end
    exp_q.push_back(e);
    @(negedge vga_clk);
  endtask

  function automatic bit in_set(input int set, input int y);
    case (set)
      1:       return y inside {0, 1, 2, 3, 150, 239, 240, 241, 477, 478, 479, 480, 524};
      2:       return y inside {0, 479};
      3:       return y inside {0, 240, 479, 480};
      default: return 1'b0;
    endcase
  endfunction

  // Full lines sweep DrawX 0..799; other lines present only DrawX==0 to step the row.
  task automatic run_line(input int y, input bit full, input int mode);
    if (full) begin
      for (int x = 0; x < 800; x++) drive(x, y, 1'b0, mode);
    end else begin
      drive(0, y, 1'b0, mode);
    end
  endtask

  task automatic run_frame(input int set);
    for (int y = 0; y < 525; y++) run_line(y, in_set(set, y), MODE_EXACT);
  endtask

  initial begin
    bus.DrawX        = '0;
    bus.DrawY        = '0;
    bus.blank        = 1'b0;
    bus.scroll_en    = 1'b0;
    bus.scroll_speed = '0;
    @(negedge vga_clk);

    phase = "reset";
    for (int i = 0; i < 3; i++) drive(0, 0, 1'b1, MODE_EXACT);

    phase = "frame_noscroll";
    run_frame(1);

    phase = "scroll_frames";
    bus.scroll_en    = 1'b1;
    bus.scroll_speed = SPEED_W'(5);
    run_frame(0);
    run_frame(0);
    phase = "scroll10";
    run_frame(2);
    phase = "scroll_wrap";
    for (int f = 0; f < 57; f++) run_frame(0);
    check("scroll_wrap", "scroll_off_60_frames", int'(bus.scroll_off), 0);

    phase = "mid_toggle";
    for (int y = 0; y < 525; y++) begin
      if (y == 100) bus.scroll_speed = SPEED_W'(7);
      if (y == 200) bus.scroll_en = 1'b0;
      if (y == 300) bus.scroll_speed = SPEED_W'(2);
      if (y == 400) bus.scroll_en = 1'b1;
      run_line(y, y inside {0, 479}, MODE_EXACT);
    end
    check("mid_toggle", "scroll_off_after", int'(bus.scroll_off), 2);

    phase = "mid_reset";
    bus.scroll_en = 1'b0;
    for (int y = 0; y < 525; y++) begin
      if (y == 240) begin
        for (int x = 0; x < 800; x++) begin
          if (x == 320) drive(x, y, 1'b1, MODE_EXACT);
          else drive(x, y, 1'b0, (x > 320) ? MODE_BOUND : MODE_EXACT);
        end
      end else begin
        run_line(y, y inside {241, 479, 480}, (y > 240) ? MODE_BOUND : MODE_EXACT);
      end
    end

    phase = "recover";
    run_frame(3);

    repeat (2) @(negedge vga_clk);
    check("end", "queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
